// File: rtl/reg2axi_pkg.sv
// rtl/reg2axi_pkg.sv - shared types and constants for the register-to-AXI4-Lite master
package reg2axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] AXCACHE_DEFAULT = 4'b0000;

endpackage

// File: rtl/reg2axi4lite_master.sv
// rtl/reg2axi4lite_master.sv - single-outstanding AXI4-Lite master fed by a valid/ready request port
// Optional saturating error counter on err_clr/err_count: define REG2AXI_ERR_CNT_EN.
module reg2axi4lite_master
    import reg2axi_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] AXPROT     = 3'b000,
    parameter int         ERR_CNT_W  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [3:0]            AWCACHE,
    output logic [2:0]            AWPROT,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [3:0]            WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [3:0]            ARCACHE,
    output logic [2:0]            ARPROT,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
`ifdef REG2AXI_ERR_CNT_EN
    ,
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  err_count
`endif
);

    // WSTRB is fixed at 4 bits, so only a 32-bit data path is meaningful.
    if (DATA_WIDTH != 32 || ERR_CNT_W < 1) begin : g_unsupported_params
    end

    state_e r_state;
    state_e w_state_nxt;

    logic                  r_awvalid, w_awvalid_nxt;
    logic                  r_wvalid,  w_wvalid_nxt;
    logic                  r_bready,  w_bready_nxt;
    logic                  r_arvalid, w_arvalid_nxt;
    logic                  r_rready,  w_rready_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr,  w_awaddr_nxt;
    logic [ADDR_WIDTH-1:0] r_araddr,  w_araddr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,   w_wdata_nxt;
    logic [3:0]            r_wstrb,   w_wstrb_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]            r_rsp_resp,  w_rsp_resp_nxt;

    // A channel counts as done once its VALID has already dropped or is handshaking now.
    logic w_aw_done;
    logic w_w_done;
    assign w_aw_done = !r_awvalid || AWREADY;
    assign w_w_done  = !r_wvalid  || WREADY;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = req_write ? WR_AW_W : RD_AR;
            WR_AW_W: if (w_aw_done && w_w_done) w_state_nxt = WR_B;
            WR_B:    if (BVALID) w_state_nxt = RSP;
            RD_AR:   if (ARREADY) w_state_nxt = RD_R;
            RD_R:    if (RVALID) w_state_nxt = RSP;
            RSP:     if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_awaddr_nxt    = r_awaddr;
        w_araddr_nxt    = r_araddr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        w_awaddr_nxt  = req_addr;
                        w_wdata_nxt   = req_wdata;
                        w_wstrb_nxt   = req_wstrb;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_araddr_nxt  = req_addr;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                if (AWREADY) w_awvalid_nxt = 1'b0;
                if (WREADY)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done && w_w_done) w_bready_nxt = 1'b1;
            end
            WR_B: begin
                if (BVALID) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_resp_nxt  = BRESP;
                end
            end
            RD_AR: begin
                if (ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            RD_R: begin
                if (RVALID) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = RDATA;
                    w_rsp_resp_nxt  = RRESP;
                end
            end
            RSP: begin
                if (rsp_ready) w_rsp_valid_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_araddr    <= w_araddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign AWADDR    = r_awaddr;
    assign AWCACHE   = AXCACHE_DEFAULT;
    assign AWPROT    = AXPROT;
    assign AWVALID   = r_awvalid;
    assign WDATA     = r_wdata;
    assign WSTRB     = r_wstrb;
    assign WVALID    = r_wvalid;
    assign BREADY    = r_bready;
    assign ARADDR    = r_araddr;
    assign ARCACHE   = AXCACHE_DEFAULT;
    assign ARPROT    = AXPROT;
    assign ARVALID   = r_arvalid;
    assign RREADY    = r_rready;

`ifdef REG2AXI_ERR_CNT_EN
    logic                 w_resp_capture;
    logic [1:0]           w_resp_in;
    logic [ERR_CNT_W-1:0] r_err_count;

    assign w_resp_capture = ((r_state == WR_B) && BVALID) || ((r_state == RD_R) && RVALID);
    assign w_resp_in      = (r_state == WR_B) ? BRESP : RRESP;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_resp_capture && (w_resp_in != RESP_OKAY) && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
